// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit multi-cycle processor control path:
// state encodings, opcodes, ALU operation codes and the control strobe bundle.
package proc_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMM_W_DEF  = 4;
  localparam int unsigned OPC_W      = 4;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'h0;
  localparam opcode_t OP_SUB  = 4'h1;
  localparam opcode_t OP_AND  = 4'h2;
  localparam opcode_t OP_OR   = 4'h3;
  localparam opcode_t OP_ADDI = 4'h4;
  localparam opcode_t OP_ANDI = 4'h5;
  localparam opcode_t OP_LW   = 4'h6;
  localparam opcode_t OP_SW   = 4'h7;
  localparam opcode_t OP_BEQ  = 4'h8;
  localparam opcode_t OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  // Per-cycle datapath strobes produced by the sequencer
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    addr_sel;
    logic    ir_write;
    logic    pc_inc;
    logic    pc_branch;
    logic    reg_write;
    logic    wb_sel;
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    illegal;
  } ctrl_t;

  // Opcodes whose immediate field is a signed offset/operand
  function automatic logic is_sext_op(input opcode_t op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extender: widens an IMM_W field to DATA_W,
// replicating the top bit when sign_ext is set, zero-filling otherwise.
module imm_extend #(
  parameter int unsigned IMM_W  = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext_c
);

  localparam int unsigned PAD_W = DATA_W - IMM_W;

  logic [PAD_W-1:0] pad;

  assign pad   = sign_ext ? {PAD_W{imm[IMM_W-1]}} : {PAD_W{1'b0}};
  assign ext_c = {pad, imm};

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: walks each instruction through
// fetch/decode/execute/mem/writeback and drives the datapath strobes.
module multicycle_control
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned IMM_W    = IMM_W_DEF,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [15:0]       instr,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              addr_sel,
  output logic              ir_write,
  output logic              pc_inc,
  output logic              pc_branch,
  output logic              reg_write,
  output logic              wb_sel,
  output logic [1:0]        alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm_ext,
  output logic              illegal,
  output logic              halted,
  output logic              mem_timeout,
  output logic [2:0]        state_dbg
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  state_t            state_q, state_d;
  opcode_t           opcode_q;
  opcode_t           dec_op;
  logic [DATA_W-1:0] imm_ext_q;
  logic [DATA_W-1:0] imm_raw;
  logic              sext_sel;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              wait_expired;
  logic              timeout_q;
  logic              timeout_set;
  ctrl_t             ctrl;
  logic              unused_instr;

  assign dec_op       = instr[15:12];
  assign sext_sel     = is_sext_op(dec_op);
  assign unused_instr = ^instr[11:IMM_W];

  // The increment on this cycle would land on WAIT_MAX
  assign wait_expired = (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

  imm_extend #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W)
  ) u_imm_extend (
    .imm     (instr[IMM_W-1:0]),
    .sign_ext(sext_sel),
    .ext_c   (imm_raw)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d     = state_q;
    ctrl        = '0;
    timeout_set = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (en) begin
          ctrl.mem_req = 1'b1;
          if (mem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_inc   = 1'b1;
            state_d       = ST_DECODE;
          end else if (wait_expired) begin
            timeout_set = 1'b1;
            state_d     = ST_HALT;
          end
        end
      end

      ST_DECODE: state_d = ST_EXECUTE;

      ST_EXECUTE: begin
        state_d = ST_FETCH;
        case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ctrl.alu_op = alu_op_t'(opcode_q[1:0]);
            state_d     = ST_WRITEBACK;
          end
          OP_ADDI: begin
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_imm = 1'b1;
            state_d          = ST_WRITEBACK;
          end
          OP_ANDI: begin
            ctrl.alu_op      = ALU_AND;
            ctrl.alu_src_imm = 1'b1;
            state_d          = ST_WRITEBACK;
          end
          OP_LW, OP_SW: begin
            ctrl.alu_op      = ALU_ADD;
            ctrl.alu_src_imm = 1'b1;
            state_d          = ST_MEM;
          end
          OP_BEQ: begin
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_branch = alu_zero;
          end
          OP_HALT: state_d = ST_HALT;
          default: ctrl.illegal = 1'b1;
        endcase
      end

      ST_MEM: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = 1'b1;
        ctrl.mem_we   = (opcode_q == OP_SW);
        if (mem_ready) begin
          state_d = (opcode_q == OP_LW) ? ST_WRITEBACK : ST_FETCH;
        end else if (wait_expired) begin
          timeout_set = 1'b1;
          state_d     = ST_HALT;
        end
      end

      ST_WRITEBACK: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = (opcode_q == OP_LW);
        state_d        = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase

    // Strobes must drop the moment reset asserts, even mid-wait
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  // Memory wait counter: restarts on each new memory phase or completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
      wait_cnt_q <= '0;
    end else if (ctrl.mem_req && mem_ready) begin
      wait_cnt_q <= '0;
    end else if (ctrl.mem_req) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end
  end

  // Opcode and immediate captured once per instruction in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= OP_ADD;
      imm_ext_q <= '0;
    end else if (state_q == ST_DECODE) begin
      opcode_q  <= dec_op;
      imm_ext_q <= (sext_sel || (dec_op == OP_ANDI)) ? imm_raw : '0;
    end
  end

  assign mem_req     = ctrl.mem_req;
  assign mem_we      = ctrl.mem_we;
  assign addr_sel    = ctrl.addr_sel;
  assign ir_write    = ctrl.ir_write;
  assign pc_inc      = ctrl.pc_inc;
  assign pc_branch   = ctrl.pc_branch;
  assign reg_write   = ctrl.reg_write;
  assign wb_sel      = ctrl.wb_sel;
  assign alu_op      = ctrl.alu_op;
  assign alu_src_imm = ctrl.alu_src_imm;
  assign illegal     = ctrl.illegal;
  assign imm_ext     = imm_ext_q;
  assign halted      = (state_q == ST_HALT);
  assign mem_timeout = timeout_q;
  assign state_dbg   = state_q;

endmodule
